// File: rtl/kpd_pkg.sv
// Shared definitions for the keypad scanner: matrix geometry, scanner
// FSM encoding and the column/row to key-code mapping.
package kpd_pkg;

  localparam int KPD_COLS   = 4;
  localparam int KPD_CODE_W = 4;

  typedef enum logic [1:0] {
    ST_SCAN      = 2'd0,
    ST_DEB_PRESS = 2'd1,
    ST_HELD      = 2'd2,
    ST_DEB_REL   = 2'd3
  } kpd_state_e;

  // Key code = 4*((col+3) mod 4) + row, where row is the lowest asserted
  // sense bit (sense given active-high here). The 2-bit add wraps mod 4,
  // so the code is simply the concatenation {col+3, row}.
  function automatic logic [KPD_CODE_W-1:0] kpd_code(input logic [1:0] col,
                                                     input logic [KPD_COLS-1:0] sense);
    logic [1:0] row;
    logic [1:0] grp;
    row = 2'd0;
    for (int i = KPD_COLS - 1; i >= 0; i--) begin
      if (sense[i]) begin
        row = 2'(i);
      end else begin
        row = row;
      end
    end
    grp = col + 2'd3;
    return {grp, row};
  endfunction

endpackage

// File: rtl/kpd_evt_fifo.sv
// Key-event FIFO. Output data comes straight from the storage flops at the
// read pointer, so a pushed entry becomes visible one cycle after the push.
module kpd_evt_fifo
  import kpd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [KPD_CODE_W-1:0] din,
  output logic [KPD_CODE_W-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [KPD_CODE_W-1:0] mem_q [DEPTH];
  logic [KPD_CODE_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_en_s;
  logic                  rd_en_s;

  assign empty = (count_q == CW'(0));
  assign full  = (count_q == CW'(DEPTH));
  assign dout  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; a pop frees a slot for
  // a same-cycle push when full, and a pop on empty is ignored.
  always_comb begin
    rd_en_s  = pop && !empty;
    wr_en_s  = push && (!full || rd_en_s);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset empties the queue and clears storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/kpd_scan_ctrl.sv
// 4x4 keypad scanner: drives one column low at a time, samples the
// synchronized sense lines once per dwell, debounces press and release,
// and queues one key code per accepted press.
module kpd_scan_ctrl
  import kpd_pkg::*;
#(
  parameter int DWELL    = 1000,
  parameter int DEBOUNCE = 4,
  parameter int DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [KPD_COLS-1:0]   col_n,
  input  logic [KPD_COLS-1:0]   sense_n,
  output logic [KPD_CODE_W-1:0] key_code,
  output logic                  key_valid,
  input  logic                  key_ready,
  output logic                  key_down,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [BW-1:0] DEB_TARGET = BW'(DEBOUNCE);

  logic [KPD_COLS-1:0]   sync1_q, sync1_d;
  logic [KPD_COLS-1:0]   sync2_q, sync2_d;
  logic [DW-1:0]         dwell_q, dwell_d;
  logic [1:0]            col_q, col_d;
  logic [KPD_COLS-1:0]   col_n_q, col_n_d;
  kpd_state_e            state_q, state_d;
  logic [BW-1:0]         deb_q, deb_d;
  logic [KPD_CODE_W-1:0] code_q, code_d;
  logic                  key_down_q, key_down_d;
  logic                  overflow_q, overflow_d;

  logic                  sample_s;
  logic                  hit_s;
  logic [KPD_CODE_W-1:0] cur_code_s;
  logic [BW-1:0]         deb_inc_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;

  assign col_n     = col_n_q;
  assign key_down  = key_down_q;
  assign overflow  = overflow_q;
  assign key_valid = !fifo_empty_s;
  assign pop_s     = key_valid && key_ready;

  // Synchronizer and free-running dwell counter; a sample is taken on the
  // last dwell cycle, long after the synchronizer has settled.
  always_comb begin
    sync1_d = sense_n;
    sync2_d = sync1_q;
    if (dwell_q == DWELL_LAST) begin
      dwell_d = '0;
    end else begin
      dwell_d = dwell_q + DW'(1);
    end
    sample_s   = (dwell_q == DWELL_LAST);
    hit_s      = |(~sync2_q);
    cur_code_s = kpd_code(col_q, ~sync2_q);
    deb_inc_s  = deb_q + BW'(1);
  end

  // Scan/debounce FSM: the column stays frozen from first hit until the key
  // is released or the press is rejected; push fires on entry to HELD.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    deb_d   = deb_q;
    code_d  = code_q;
    push_s  = 1'b0;
    if (sample_s) begin
      case (state_q)
        ST_SCAN: begin
          if (hit_s) begin
            code_d  = cur_code_s;
            deb_d   = BW'(1);
            state_d = ST_DEB_PRESS;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        ST_DEB_PRESS: begin
          if (hit_s && (cur_code_s == code_q)) begin
            if (deb_inc_s == DEB_TARGET) begin
              deb_d   = '0;
              state_d = ST_HELD;
              push_s  = 1'b1;
            end else begin
              deb_d = deb_inc_s;
            end
          end else begin
            deb_d   = '0;
            state_d = ST_SCAN;
            col_d   = col_q + 2'd1;
          end
        end
        ST_HELD: begin
          if (!hit_s) begin
            deb_d   = BW'(1);
            state_d = ST_DEB_REL;
          end else begin
            state_d = ST_HELD;
          end
        end
        ST_DEB_REL: begin
          if (hit_s) begin
            deb_d   = '0;
            state_d = ST_HELD;
          end else if (deb_inc_s == DEB_TARGET) begin
            deb_d   = '0;
            state_d = ST_SCAN;
            col_d   = col_q + 2'd1;
          end else begin
            deb_d = deb_inc_s;
          end
        end
        default: begin
          deb_d   = '0;
          state_d = ST_SCAN;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    col_n_d    = ~(4'b0001 << col_d);
    key_down_d = (state_d == ST_HELD) || (state_d == ST_DEB_REL);
  end

  // Sticky overflow: a push dropped on a full FIFO wins over a clear.
  always_comb begin
    if (push_s && fifo_full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 4'b1111;
      sync2_q    <= 4'b1111;
      dwell_q    <= '0;
      col_q      <= 2'd0;
      col_n_q    <= 4'b1110;
      state_q    <= ST_SCAN;
      deb_q      <= '0;
      code_q     <= 4'd0;
      key_down_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      dwell_q    <= dwell_d;
      col_q      <= col_d;
      col_n_q    <= col_n_d;
      state_q    <= state_d;
      deb_q      <= deb_d;
      code_q     <= code_d;
      key_down_q <= key_down_d;
      overflow_q <= overflow_d;
    end
  end

  kpd_evt_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (code_q),
    .dout  (key_code),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

endmodule
